// File: rtl/stc_pkg.sv
// Shared sizing and state types for the core result path.
package stc_pkg;

  localparam int unsigned DW_ADD  = 32;
  localparam int unsigned N_GROUP = 4;
  localparam int unsigned N_UNIT  = 4;
  localparam int unsigned N_ELEM  = N_GROUP * N_UNIT;
  localparam int unsigned DW_IDX  = $clog2(N_ELEM);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

endpackage

// File: rtl/core_result_drain_nz_next_idx.sv
// Priority encoder: lowest nonzero element index strictly above cur_idx.
// Only present in builds with DRAIN_SKIP_ZERO_EN defined.
`ifdef DRAIN_SKIP_ZERO_EN
module nz_next_idx #(
  parameter int unsigned N_ELEM = stc_pkg::N_ELEM,
  parameter int unsigned DW_IDX = stc_pkg::DW_IDX
) (
  input  logic [N_ELEM-1:0] nz_mask,
  input  logic [DW_IDX-1:0] cur_idx,
  output logic [DW_IDX-1:0] next_idx_c,
  output logic              none_left_c
);

  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    next_idx_c  = '0;
    none_left_c = 1'b1;
    for (int i = int'(N_ELEM) - 1; i >= 0; i--) begin
      if (nz_mask[i] && (32'(i) > 32'(cur_idx))) begin
        next_idx_c  = DW_IDX'(i);
        none_left_c = 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/core_result_drain.sv
// Captures a core result tile and streams it one element per beat (valid/ready).
// Build option DRAIN_SKIP_ZERO_EN suppresses zero-valued elements.
module core_result_drain #(
  parameter int unsigned N_GROUP  = stc_pkg::N_GROUP,
  parameter int unsigned N_UNIT   = stc_pkg::N_UNIT,
  parameter int unsigned DW_ADD   = stc_pkg::DW_ADD,
  parameter int unsigned CORE_LAT = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [1:0]                            in_valid,
  input  logic [DW_ADD*N_GROUP*N_UNIT-1:0]      core_out,
  output logic signed [DW_ADD-1:0]              out_data,
  output logic [$clog2(N_GROUP*N_UNIT)-1:0]     out_idx,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  overflow
);
  import stc_pkg::*;

  localparam int unsigned N_ELEM      = N_GROUP * N_UNIT;
  localparam int unsigned DW_CORE_OUT = DW_ADD * N_ELEM;
  localparam int unsigned DW_IDX      = $clog2(N_ELEM);
  localparam logic [DW_IDX-1:0] LAST_IDX = DW_IDX'(N_ELEM - 1);

  drain_state_e            state_q, state_d;
  logic [CORE_LAT-1:0]     pipe_q, pipe_d;
  logic [DW_CORE_OUT-1:0]  capture_q, capture_d;
  logic [DW_IDX-1:0]       idx_q, idx_d;
  logic                    overflow_q, overflow_d;
  logic signed [DW_ADD-1:0] out_data_q, out_data_d;
  logic [DW_IDX-1:0]       out_idx_q, out_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;

  logic                    issue_c, cap_c, handshake_c, tile_done_c;
  logic [DW_IDX-1:0]       load_idx_c, adv_idx_c;
  logic                    cur_last_c, next_last_c;

  assign issue_c     = enable && (in_valid == 2'b11);
  assign cap_c       = pipe_q[CORE_LAT-1];
  assign handshake_c = out_valid_q && out_ready;
  assign tile_done_c = handshake_c && cur_last_c;

`ifdef DRAIN_SKIP_ZERO_EN
  logic [N_ELEM-1:0] in_nz_c, cap_nz_c, nxt_nz_c;
  logic [DW_IDX-1:0] first_above0_c, unused_last_idx_c;
  logic              first_none_c;

  always_comb begin
    in_nz_c  = '0;
    cap_nz_c = '0;
    for (int unsigned j = 0; j < N_ELEM; j++) begin
      in_nz_c[j]  = |core_out[j*DW_ADD +: DW_ADD];
      cap_nz_c[j] = |capture_q[j*DW_ADD +: DW_ADD];
    end
  end

  always_comb begin
    nxt_nz_c = '0;
    for (int unsigned j = 0; j < N_ELEM; j++) begin
      nxt_nz_c[j] = |capture_d[j*DW_ADD +: DW_ADD];
    end
  end

  nz_next_idx #(.N_ELEM(N_ELEM), .DW_IDX(DW_IDX)) u_first (
    .nz_mask(in_nz_c), .cur_idx('0),
    .next_idx_c(first_above0_c), .none_left_c(first_none_c)
  );

  nz_next_idx #(.N_ELEM(N_ELEM), .DW_IDX(DW_IDX)) u_adv (
    .nz_mask(cap_nz_c), .cur_idx(idx_q),
    .next_idx_c(adv_idx_c), .none_left_c(cur_last_c)
  );

  nz_next_idx #(.N_ELEM(N_ELEM), .DW_IDX(DW_IDX)) u_last (
    .nz_mask(nxt_nz_c), .cur_idx(idx_d),
    .next_idx_c(unused_last_idx_c), .none_left_c(next_last_c)
  );

  // An all-zero tile still emits its final slot so the tile boundary survives.
  assign load_idx_c = in_nz_c[0]   ? '0 :
                      first_none_c ? LAST_IDX : first_above0_c;
`else
  assign load_idx_c  = '0;
  assign adv_idx_c   = idx_q + DW_IDX'(1);
  assign cur_last_c  = (idx_q == LAST_IDX);
  assign next_last_c = (idx_d == LAST_IDX);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pipe_q      <= '0;
      capture_q   <= '0;
      idx_q       <= '0;
      overflow_q  <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pipe_q      <= pipe_d;
      capture_q   <= capture_d;
      idx_q       <= idx_d;
      overflow_q  <= overflow_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: capture, advance, back-to-back reload, or drop with overflow.
  always_comb begin
    state_d    = state_q;
    pipe_d     = CORE_LAT'({pipe_q, issue_c});
    capture_d  = capture_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (cap_c) begin
          capture_d = core_out;
          idx_d     = load_idx_c;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tile_done_c) begin
          if (cap_c) begin
            capture_d = core_out;
            idx_d     = load_idx_c;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end else begin
          if (handshake_c) idx_d = adv_idx_c;
          if (cap_c) overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat fields are registered from the post-edge capture and index.
  always_comb begin
    out_valid_d = (state_d == SEND);
    busy_d      = (state_d == SEND);
    out_idx_d   = out_valid_d ? idx_d : '0;
    out_data_d  = out_valid_d ? capture_d[DW_ADD*32'(idx_d) +: DW_ADD] : '0;
    out_last_d  = out_valid_d && next_last_c;
  end

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_core_result_drain.sv
// Randomized/directed bench for core_result_drain against a beat-queue reference model.
module tb_core_result_drain;
  localparam int unsigned N_GROUP     = 4;
  localparam int unsigned N_UNIT      = 4;
  localparam int unsigned DW_ADD      = 32;
  localparam int unsigned CORE_LAT    = 2;
  localparam int unsigned N_ELEM      = N_GROUP * N_UNIT;
  localparam int unsigned DW_CORE_OUT = DW_ADD * N_ELEM;
  localparam int unsigned DW_IDX      = $clog2(N_ELEM);

  typedef struct {
    logic [DW_ADD-1:0] data;
    logic [DW_IDX-1:0] idx;
    logic              last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [1:0]             in_valid;
  logic [DW_CORE_OUT-1:0] core_out;
  logic signed [DW_ADD-1:0] out_data;
  logic [DW_IDX-1:0]      out_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   busy;
  logic                   overflow;

  core_result_drain #(
    .N_GROUP(N_GROUP), .N_UNIT(N_UNIT), .DW_ADD(DW_ADD), .CORE_LAT(CORE_LAT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .core_out(core_out), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: queue of beats still owed from the current tile, plus capture due times.
  beat_t       exp_q[$];
  int unsigned due_q[$];
  int unsigned edge_n = 0;
  logic        exp_ovf = 1'b0;
  bit          rand_data = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [DW_CORE_OUT-1:0] rand_tile();
    logic [DW_CORE_OUT-1:0] t;
    t = '0;
    for (int j = 0; j < int'(N_ELEM); j++)
      if ($urandom_range(0, 3) != 0) t[j*DW_ADD +: DW_ADD] = $urandom;
    return t;
  endfunction

  task automatic load_tile(input logic [DW_CORE_OUT-1:0] t);
    beat_t b;
    logic [DW_ADD-1:0] e;
    exp_q.delete();
    for (int j = 0; j < int'(N_ELEM); j++) begin
      e = t[j*DW_ADD +: DW_ADD];
      b.data = e; b.idx = DW_IDX'(j); b.last = 1'b0;
`ifdef DRAIN_SKIP_ZERO_EN
      if (e != '0) exp_q.push_back(b);
`else
      exp_q.push_back(b);
`endif
    end
    if (exp_q.size() == 0) begin
      b.data = '0; b.idx = DW_IDX'(N_ELEM - 1); b.last = 1'b0;
      exp_q.push_back(b);
    end
    b = exp_q.pop_back();
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic model_edge(input logic en, input logic [1:0] iv, input logic rdy, input logic rst);
    beat_t b;
    int unsigned d;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (exp_q.size() > 0 && rdy) b = exp_q.pop_front();
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        d = due_q.pop_front();
        if (exp_q.size() == 0) load_tile(core_out);
        else exp_ovf = 1'b1;
      end
      if (en && iv == 2'b11) due_q.push_back(edge_n + CORE_LAT);
    end
    edge_n++;
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (exp_q.size() > 0);
    checks++;
    assert (out_valid === ev) else begin
      failures++; $error("FAIL valid t=%0t got=%b exp=%b", $time, out_valid, ev);
    end
    checks++;
    assert (busy === ev) else begin
      failures++; $error("FAIL busy t=%0t got=%b exp=%b", $time, busy, ev);
    end
    checks++;
    assert (overflow === exp_ovf) else begin
      failures++; $error("FAIL overflow t=%0t got=%b exp=%b", $time, overflow, exp_ovf);
    end
    if (ev) begin
      checks++;
      assert (out_data === exp_q[0].data) else begin
        failures++; $error("FAIL data t=%0t got=%0h exp=%0h", $time, out_data, exp_q[0].data);
      end
      checks++;
      assert (out_idx === exp_q[0].idx) else begin
        failures++; $error("FAIL idx t=%0t got=%0d exp=%0d", $time, out_idx, exp_q[0].idx);
      end
      checks++;
      assert (out_last === exp_q[0].last) else begin
        failures++; $error("FAIL last t=%0t got=%b exp=%b", $time, out_last, exp_q[0].last);
      end
    end
  endtask

  task automatic cycle(input logic en, input logic [1:0] iv, input logic rdy, input logic rst);
    enable = en; in_valid = iv; out_ready = rdy; reset = rst;
    if (rand_data) core_out = rand_tile();
    model_edge(en, iv, rdy, rst);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic ramp_tile();
    for (int j = 0; j < int'(N_ELEM); j++) core_out[j*DW_ADD +: DW_ADD] = DW_ADD'(j + 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 2'b00; out_ready = 1'b0; core_out = '0;

    // Reset state
    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 2'b11, 1'b0, 1'b1);
    checks++;
    assert (out_data === '0 && out_idx === '0 && out_last === 1'b0) else begin
      failures++; $error("FAIL reset_fields got=%0h/%0d/%b exp=0/0/0", out_data, out_idx, out_last);
    end

    // Single issue, ramp data, ready held high
    ramp_tile();
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    checks++;
    assert (out_valid === 1'b0) else begin
      failures++; $error("FAIL early_valid got=%b exp=0", out_valid);
    end
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    checks++;
    assert (out_valid === 1'b1 && out_idx === '0 && out_data === 32'sd1) else begin
      failures++; $error("FAIL first_beat got=%b/%0d/%0d exp=1/0/1", out_valid, out_idx, out_data);
    end
    repeat (20) cycle(1'b0, 2'b00, 1'b1, 1'b0);

    // Backpressure pattern 1,0,0,1
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 70; i++) cycle(1'b0, 2'b00, (i % 4 == 0) || (i % 4 == 3), 1'b0);

    // Back-to-back tiles 16 cycles apart: no bubble, no overflow
    rand_data = 1'b1;
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (15) cycle(1'b0, 2'b00, 1'b1, 1'b0);
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (40) cycle(1'b0, 2'b00, 1'b1, 1'b0);

    // Second issue 5 cycles later: dropped with overflow
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 2'b00, 1'b1, 1'b0);
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (30) cycle(1'b0, 2'b00, 1'b1, 1'b0);

    // Non-issue qualifier combinations
    cycle(1'b1, 2'b01, 1'b1, 1'b0);
    cycle(1'b0, 2'b11, 1'b1, 1'b0);
    cycle(1'b1, 2'b10, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 2'b00, 1'b1, 1'b0);

    // Reset mid-tile, then a fresh tile
    rand_data = 1'b0;
    ramp_tile();
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (9) cycle(1'b0, 2'b00, 1'b1, 1'b0);
    cycle(1'b1, 2'b11, 1'b1, 1'b1);
    checks++;
    assert (out_valid === 1'b0 && overflow === 1'b0) else begin
      failures++; $error("FAIL reset_mid got=%b/%b exp=0/0", out_valid, overflow);
    end
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (20) cycle(1'b0, 2'b00, 1'b1, 1'b0);

    // Sparse tile and all-zero tile
    core_out = '0;
    core_out[2*DW_ADD +: DW_ADD]  = -32'sd5;
    core_out[9*DW_ADD +: DW_ADD]  = 32'sd7;
    core_out[15*DW_ADD +: DW_ADD] = 32'sd100;
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (20) cycle(1'b0, 2'b00, 1'b1, 1'b0);
    core_out = '0;
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (20) cycle(1'b0, 2'b00, 1'b1, 1'b0);

    // Random traffic
    rand_data = 1'b1;
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
